// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch predictor for the pipelined RAT core.
// A direct-mapped table of 2-bit saturating counters is looked up
// combinationally at fetch and trained at branch resolution in execute.
// After reset a sequential sweep writes INIT_CTR into every entry; no
// prediction or training happens until the sweep finishes.
// Optional build macro: BRANCH_PRED_STATS_EN compiles in 16-bit saturating
// resolved-branch / misprediction counters; otherwise stat_* read zero.
module branch_predictor #(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned IDX_W    = 4,
   parameter logic [1:0]  INIT_CTR = 2'b01
) (
   input  logic            clk,
   input  logic            reset,
   // fetch-side lookup
   input  logic            fetch_valid,
   input  logic            fetch_is_branch,
   input  logic [PC_W-1:0] fetch_pc,
   input  logic [PC_W-1:0] fetch_target,
   output logic            predicted_branch_taken,
   output logic [PC_W-1:0] pred_target,
   // execute-side resolution
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [PC_W-1:0] ex_target,
   input  logic            ex_taken,
   input  logic            ex_pred_taken,
   output logic            branch_miss,
   output logic [PC_W-1:0] recover_pc,
   // status
   output logic            ready,
   output logic [15:0]     stat_branches,
   output logic [15:0]     stat_misses
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] sweep_idx;
   logic             ready_q;
   logic [1:0]       ctr_table [ENTRIES];

   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             run;
   logic             res;
   logic             miss;
   logic [1:0]       ex_ctr;
   logic [1:0]       ex_ctr_next;

   assign fetch_idx = fetch_pc[IDX_W-1:0];
   assign ex_idx    = ex_pc[IDX_W-1:0];

   // A synchronous reset only takes effect at the next edge, so gate with
   // reset here to keep every output quiet for the whole reset cycle.
   assign run  = (state == RUN) && !reset;
   assign res  = run && ex_valid && ex_is_branch;
   assign miss = res && (ex_taken != ex_pred_taken);

   // Lookup reads the registered table, so a same-cycle training write to
   // the same entry is only seen by the following cycle's lookup.
   assign predicted_branch_taken = run && fetch_valid && fetch_is_branch
                                   && ctr_table[fetch_idx][1] && !miss;
   assign pred_target = fetch_target;

   assign branch_miss = miss;
   assign recover_pc  = ex_taken ? ex_target : (ex_pc + PC_W'(1));

   assign ready = ready_q && !reset;

   // Saturating next-state for the counter being trained.
   always_comb begin
      ex_ctr      = ctr_table[ex_idx];
      ex_ctr_next = ex_ctr;
      if (ex_taken) begin
         if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'd1;
      end else begin
         if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'd1;
      end
   end

   // Init sweep / run sequencing with registered ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         sweep_idx <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               sweep_idx <= sweep_idx + IDX_W'(1);
               if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state     <= INIT;
               sweep_idx <= '0;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   // Counter table: sweep writes during INIT, training writes on resolution.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            ctr_table[sweep_idx] <= INIT_CTR;
         end else if (res) begin
            ctr_table[ex_idx] <= ex_ctr_next;
         end
      end
   end

`ifdef BRANCH_PRED_STATS_EN
   logic [15:0] stat_br_q;
   logic [15:0] stat_ms_q;

   // Saturating resolved-branch and misprediction counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_ms_q <= '0;
      end else begin
         if (res && (stat_br_q != '1)) stat_br_q <= stat_br_q + 16'd1;
         if (miss && (stat_ms_q != '1)) stat_ms_q <= stat_ms_q + 16'd1;
      end
   end

   assign stat_branches = reset ? '0 : stat_br_q;
   assign stat_misses   = reset ? '0 : stat_ms_q;
`else
   assign stat_branches = '0;
   assign stat_misses   = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan scenarios plus randomized traffic,
// checked each cycle against a behavioural model of the predictor table.
// STATS_EN must match whether BRANCH_PRED_STATS_EN is defined for the DUT.
module tb_branch_predictor;

   localparam int unsigned PC_W    = 10;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned N       = 16;
   localparam int          INIT    = 1;
   localparam bit          STATS_EN = 1'b0;
   localparam int          SAT_RUN = 70000;

   logic            clk = 1'b0;
   logic            reset;
   logic            fetch_valid, fetch_is_branch;
   logic [PC_W-1:0] fetch_pc, fetch_target;
   logic            predicted_branch_taken;
   logic [PC_W-1:0] pred_target;
   logic            ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
   logic [PC_W-1:0] ex_pc, ex_target;
   logic            branch_miss;
   logic [PC_W-1:0] recover_pc;
   logic            ready;
   logic [15:0]     stat_branches, stat_misses;

   always #5 clk = ~clk;

   branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .INIT_CTR(2'b01)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .fetch_valid            (fetch_valid),
      .fetch_is_branch        (fetch_is_branch),
      .fetch_pc               (fetch_pc),
      .fetch_target           (fetch_target),
      .predicted_branch_taken (predicted_branch_taken),
      .pred_target            (pred_target),
      .ex_valid               (ex_valid),
      .ex_is_branch           (ex_is_branch),
      .ex_pc                  (ex_pc),
      .ex_target              (ex_target),
      .ex_taken               (ex_taken),
      .ex_pred_taken          (ex_pred_taken),
      .branch_miss            (branch_miss),
      .recover_pc             (recover_pc),
      .ready                  (ready),
      .stat_branches          (stat_branches),
      .stat_misses            (stat_misses)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: counter values as ints, cycles elapsed since reset.
   int m_ctr [N];
   int m_sweep = 0;
   int m_br = 0;
   int m_ms = 0;

   task automatic drive_fetch(input logic v, input logic b, input int pc, input int tgt);
      fetch_valid     = v;
      fetch_is_branch = b;
      fetch_pc        = PC_W'(pc);
      fetch_target    = PC_W'(tgt);
   endtask

   task automatic drive_ex(input logic v, input logic b, input int pc, input int tgt,
                           input logic tk, input logic ptk);
      ex_valid      = v;
      ex_is_branch  = b;
      ex_pc         = PC_W'(pc);
      ex_target     = PC_W'(tgt);
      ex_taken      = tk;
      ex_pred_taken = ptk;
   endtask

   task automatic idle();
      drive_fetch(1'b0, 1'b0, 0, 0);
      drive_ex(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   // One clock: compare outputs mid-cycle, then advance the model on the edge.
   task automatic step();
      bit run, res, miss, pt;
      int ei;
      int rec;
      @(negedge clk);
      run  = !reset && (m_sweep >= N);
      res  = run && ex_valid && ex_is_branch;
      miss = res && (ex_taken != ex_pred_taken);
      pt   = run && fetch_valid && fetch_is_branch && (m_ctr[int'(fetch_pc) % N] >= 2) && !miss;
      rec  = ex_taken ? int'(ex_target) : (int'(ex_pc) + 1) % 1024;
      check("ready",       32'(ready), 32'(run));
      check("pred_taken",  32'(predicted_branch_taken), 32'(pt));
      check("pred_target", 32'(pred_target), 32'(fetch_target));
      check("branch_miss", 32'(branch_miss), 32'(miss));
      check("recover_pc",  32'(recover_pc), 32'(rec));
      check("stat_branches", 32'(stat_branches), STATS_EN ? 32'(m_br) : 32'd0);
      check("stat_misses",   32'(stat_misses),   STATS_EN ? 32'(m_ms) : 32'd0);
      @(posedge clk);
      if (reset) begin
         m_sweep = 0;
         m_br    = 0;
         m_ms    = 0;
      end else if (m_sweep < N) begin
         m_ctr[m_sweep] = INIT;
         m_sweep++;
      end else if (res) begin
         ei = int'(ex_pc) % N;
         if (ex_taken) m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
         else          m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
         if (m_br < 65535) m_br++;
         if (miss && m_ms < 65535) m_ms++;
      end
      #1;
   endtask

   initial begin
      int tk;
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;

      // Sweep: 16 cycles not ready, branch fetched at cycle 10 not predicted.
      for (int i = 0; i < int'(N); i++) begin
         idle();
         if (i == 10) drive_fetch(1'b1, 1'b1, 'h005, 'h077);
         step();
      end
      idle();
      step();

      // Taken resolution mispredicted, then same-index fetch predicts taken.
      drive_ex(1'b1, 1'b1, 'h023, 'h040, 1'b1, 1'b0);
      step();
      idle();
      drive_fetch(1'b1, 1'b1, 'h013, 'h050);
      step();

      // Wrap of recover_pc, then saturate the counter at 0.
      idle();
      drive_ex(1'b1, 1'b1, 'h3FF, 'h123, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 4; i++) begin
         drive_ex(1'b1, 1'b1, 'h3FF, 'h123, 1'b0, 1'b0);
         step();
      end
      idle();
      drive_fetch(1'b1, 1'b1, 'h00F, 'h200);
      step();

      // Miss priority and read/update collision on idx 5.
      idle();
      drive_ex(1'b1, 1'b1, 'h005, 'h010, 1'b1, 1'b1);
      step();
      drive_fetch(1'b1, 1'b1, 'h015, 'h060);
      drive_ex(1'b1, 1'b1, 'h005, 'h010, 1'b0, 1'b1);
      step();
      drive_ex(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      step();
      drive_fetch(1'b1, 1'b0, 'h035, 'h061);
      drive_ex(1'b1, 1'b0, 'h005, 'h010, 1'b1, 1'b0);
      step();

      // Reset mid-sweep restarts it from index 0.
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < int'(N) + 2; i++) begin
         drive_fetch(1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
         step();
      end

      // Long run of mispredicted branches exercises stat saturation.
      idle();
      for (int i = 0; i < SAT_RUN; i++) begin
         tk = int'($urandom_range(0, 1));
         drive_ex(1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), tk[0], !tk[0]);
         step();
      end

      // Random traffic with collisions and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         int fpc;
         fpc = int'($urandom_range(0, 1023));
         reset = ($urandom_range(0, 299) == 0);
         drive_fetch($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, fpc, $urandom_range(0, 1023));
         drive_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? (fpc ^ 'h2A0) : int'($urandom_range(0, 1023)),
                  $urandom_range(0, 1023), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
